// File: rtl/rv32_irq_evt_gen_pkg.sv
// ---------------------------------------------------------------------------
// rv32_irq_evt_gen_pkg
//   Shared types and constants for the machine-level interrupt event producer.
//   - Hart count and hart index type for the barrel core.
//   - irq_evt_t: the {valid, trap target PC} event handed to the next-PC unit.
//   - Interrupt cause codes and the per-hart controller state encoding.
//   - irq_target(): mtvec direct/vectored trap target computation.
// ---------------------------------------------------------------------------
package rv32_irq_evt_gen_pkg;

  localparam int NUM_HARTS  = 8;
  localparam int HART_CNT_W = $clog2(NUM_HARTS);
  localparam int NUM_SRC    = 3;

  // Bit positions of the sources inside each hart's 3-bit group.
  localparam int SRC_MSI = 0;
  localparam int SRC_MTI = 1;
  localparam int SRC_MEI = 2;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef logic [HART_CNT_W-1:0] rv32_hart_cnt_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } irq_evt_t;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_FIRE,
    IRQ_SERVICE
  } irq_state_e;

  // Trap target for a given cause code. Only MODE=1 vectors; the reserved
  // modes 2/3 fall back to direct mode.
  function automatic logic [31:0] irq_target(input logic [31:0] mtvec,
                                             input logic [3:0]  code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == MTVEC_VECTORED) begin
      return base + {26'b0, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/rv32_irq_evt_gen_hart_ctrl.sv
// ---------------------------------------------------------------------------
// rv32_irq_hart_ctrl
//   Interrupt control for a single hart: samples and masks the source lines,
//   picks the highest-priority pending cause, computes the trap target and
//   runs the IDLE -> FIRE -> SERVICE handshake that keeps at most one event
//   outstanding until the hart retires MRET.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   irq_src_i[2:0]  level lines {MEI,MTI,MSI}
//   mie_i[2:0]      per-source enables {MEIE,MTIE,MSIE}
//   mstatus_mie_i   global machine interrupt enable
//   mtvec_i[31:0]   trap vector base and mode
//   mret_i          MRET retired on this hart this cycle
//   irq_evt_o       registered {valid, target}; valid high for the FIRE cycle
//   mcause_o        registered cause, held between events
//   mcause_we_o     mcause write strobe, coincident with irq_evt_o.valid
//   irq_pending_o   mip view (registered src & mie)
//   in_service_o    an event was issued and MRET has not yet been seen
// ---------------------------------------------------------------------------
module rv32_irq_hart_ctrl
  import rv32_irq_evt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  irq_src_i,
  input  logic [2:0]  mie_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mtvec_i,
  input  logic        mret_i,
  output irq_evt_t    irq_evt_o,
  output logic [31:0] mcause_o,
  output logic        mcause_we_o,
  output logic [2:0]  irq_pending_o,
  output logic        in_service_o
);

  irq_state_e  state_q, state_d;
  logic [2:0]  pend_q;
  logic [3:0]  code;
  logic        take;
  logic        valid_q;
  logic [31:0] target_q;
  logic [31:0] mcause_q;

  // NOTE: every flop here is cleared by the async reset so that all outputs
  // read zero while rst_n is low, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, regardless of statement order.
      pend_q <= irq_src_i & mie_i;
    end
  end

  // Fixed priority MEI > MSI > MTI.
  always_comb begin
    // NOTE: default first, so no path leaves code unassigned (no latch).
    code = IRQ_CODE_MTI;
    if (pend_q[SRC_MEI]) begin
      code = IRQ_CODE_MEI;
    end else if (pend_q[SRC_MSI]) begin
      code = IRQ_CODE_MSI;
    end else if (pend_q[SRC_MTI]) begin
      code = IRQ_CODE_MTI;
    end
  end

  assign take = (state_q == IRQ_IDLE) && mstatus_mie_i && (|pend_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IRQ_IDLE:    if (take)   state_d = IRQ_FIRE;
      IRQ_FIRE:                state_d = IRQ_SERVICE;
      IRQ_SERVICE: if (mret_i) state_d = IRQ_IDLE;
      default:                 state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Event payload is captured on the IDLE->FIRE edge, so later mtvec/mie
  // changes cannot disturb an event already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      target_q <= '0;
      mcause_q <= '0;
    end else begin
      valid_q <= take;
      if (take) begin
        target_q <= irq_target(mtvec_i, code);
        mcause_q <= {1'b1, 27'b0, code};
      end
    end
  end

  assign irq_evt_o.valid = valid_q;
  assign irq_evt_o.data  = target_q;
  assign mcause_o        = mcause_q;
  assign mcause_we_o     = valid_q;
  assign irq_pending_o   = pend_q;
  assign in_service_o    = (state_q != IRQ_IDLE);

endmodule

// File: rtl/rv32_irq_evt_gen.sv
// ---------------------------------------------------------------------------
// rv32_irq_evt_gen
//   Producer side of the per-hart irq_evt_t channel feeding rv32_next_pc.
//   One rv32_irq_hart_ctrl per hart; this level only splits the flattened
//   buses and decodes which hart retired an MRET.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   irq_src_i       NUM_HARTS x {MEI,MTI,MSI} level lines
//   mie_i           NUM_HARTS x {MEIE,MTIE,MSIE}
//   mstatus_mie_i   NUM_HARTS global enables
//   mtvec_i         NUM_HARTS x 32-bit mtvec
//   mret_i          an MRET retired this cycle
//   mret_hart_i     hart that retired it
//   irq_evt_o       NUM_HARTS x irq_evt_t
//   mcause_o        NUM_HARTS x 32-bit cause
//   mcause_we_o     NUM_HARTS mcause write strobes
//   irq_pending_o   NUM_HARTS x 3-bit mip view
//   in_service_o    NUM_HARTS handler-active flags
// ---------------------------------------------------------------------------
module rv32_irq_evt_gen
  import rv32_irq_evt_gen_pkg::*;
#(
  parameter int NUM_HARTS = rv32_irq_evt_gen_pkg::NUM_HARTS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_HARTS*3-1:0]    irq_src_i,
  input  logic [NUM_HARTS*3-1:0]    mie_i,
  input  logic [NUM_HARTS-1:0]      mstatus_mie_i,
  input  logic [NUM_HARTS*32-1:0]   mtvec_i,
  input  logic                      mret_i,
  input  rv32_hart_cnt_t            mret_hart_i,
  output irq_evt_t [NUM_HARTS-1:0]  irq_evt_o,
  output logic [NUM_HARTS*32-1:0]   mcause_o,
  output logic [NUM_HARTS-1:0]      mcause_we_o,
  output logic [NUM_HARTS*3-1:0]    irq_pending_o,
  output logic [NUM_HARTS-1:0]      in_service_o
);

  logic [NUM_HARTS-1:0] mret_hit;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    assign mret_hit[h] = mret_i && (mret_hart_i == rv32_hart_cnt_t'(h));

    rv32_irq_hart_ctrl u_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .irq_src_i     (irq_src_i[h*3 +: 3]),
      .mie_i         (mie_i[h*3 +: 3]),
      .mstatus_mie_i (mstatus_mie_i[h]),
      .mtvec_i       (mtvec_i[h*32 +: 32]),
      .mret_i        (mret_hit[h]),
      .irq_evt_o     (irq_evt_o[h]),
      .mcause_o      (mcause_o[h*32 +: 32]),
      .mcause_we_o   (mcause_we_o[h]),
      .irq_pending_o (irq_pending_o[h*3 +: 3]),
      .in_service_o  (in_service_o[h])
    );
  end

endmodule

// File: tb/tb_rv32_irq_evt_gen.sv
// ---------------------------------------------------------------------------
// tb_rv32_irq_evt_gen
//   Directed bench for rv32_irq_evt_gen. Inputs change on the falling edge,
//   outputs are compared on the falling edge after the rising edge of interest.
// ---------------------------------------------------------------------------
module tb_rv32_irq_evt_gen;
  import rv32_irq_evt_gen_pkg::*;

  localparam int NH = rv32_irq_evt_gen_pkg::NUM_HARTS;

  logic                clk;
  logic                rst_n;
  logic [NH*3-1:0]     irq_src;
  logic [NH*3-1:0]     mie;
  logic [NH-1:0]       mstatus_mie;
  logic [NH*32-1:0]    mtvec;
  logic                mret;
  rv32_hart_cnt_t      mret_hart;
  irq_evt_t [NH-1:0]   irq_evt;
  logic [NH*32-1:0]    mcause;
  logic [NH-1:0]       mcause_we;
  logic [NH*3-1:0]     irq_pending;
  logic [NH-1:0]       in_service;

  int n_assert = 0;
  int n_fail   = 0;

  rv32_irq_evt_gen #(.NUM_HARTS(NH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_src_i     (irq_src),
    .mie_i         (mie),
    .mstatus_mie_i (mstatus_mie),
    .mtvec_i       (mtvec),
    .mret_i        (mret),
    .mret_hart_i   (mret_hart),
    .irq_evt_o     (irq_evt),
    .mcause_o      (mcause),
    .mcause_we_o   (mcause_we),
    .irq_pending_o (irq_pending),
    .in_service_o  (in_service)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic cfg_hart(input int h, input logic [31:0] tvec, input logic [2:0] en,
                          input logic gie, input logic [2:0] src);
    mtvec[h*32 +: 32] = tvec;
    mie[h*3 +: 3]     = en;
    mstatus_mie[h]    = gie;
    irq_src[h*3 +: 3] = src;
  endtask

  task automatic do_mret(input int h);
    mret      = 1'b1;
    mret_hart = rv32_hart_cnt_t'(h);
    step(1);
    mret      = 1'b0;
  endtask

  task automatic check_evt(input string tag, input int h, input logic [31:0] tgt,
                           input logic [31:0] cause);
    check({tag, "_valid"}, 64'(irq_evt[h].valid), 64'd1);
    check({tag, "_data"},  64'(irq_evt[h].data),  64'(tgt));
    check({tag, "_mcause"}, 64'(mcause[h*32 +: 32]), 64'(cause));
    check({tag, "_we"},    64'(mcause_we[h]),     64'd1);
  endtask

  initial begin
    logic saw;
    rst_n       = 1'b1;
    irq_src     = '0;
    mie         = '0;
    mstatus_mie = '0;
    mtvec       = '0;
    mret        = 1'b0;
    mret_hart   = '0;
    #1 rst_n = 1'b0;
    #3;
    check("por_valid",   64'(irq_evt),    64'd0);
    check("por_inservc", 64'(in_service), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Hart 2 enters SERVICE, then reset is applied mid-cycle.
    cfg_hart(2, 32'h0000_0300, 3'b111, 1'b1, 3'b001);
    step(1);
    check("t1_valid_early", 64'(irq_evt[2].valid), 64'd0);
    check("t1_pending",     64'(irq_pending[8:6]), 64'h1);
    step(1);
    check_evt("t1_evt", 2, 32'h0000_0300, 32'h8000_0003);
    step(1);
    check("t1_single",  64'(irq_evt[2].valid), 64'd0);
    check("t1_service", 64'(in_service[2]),    64'd1);
    irq_src[2*3 +: 3] = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_evt",     64'(irq_evt != '0),     64'd0);
    check("t1_rst_mcause",  64'(mcause != '0),      64'd0);
    check("t1_rst_we",      64'(mcause_we),         64'd0);
    check("t1_rst_pending", 64'(irq_pending),       64'd0);
    check("t1_rst_inservc", 64'(in_service),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      step(1);
      saw = saw | irq_evt[2].valid;
    end
    check("t1_no_evt_after_rst", 64'(saw),           64'd0);
    check("t1_idle_after_rst",   64'(in_service[2]), 64'd0);

    // 2. Direct mode, one-cycle MTI pulse on hart 0.
    cfg_hart(0, 32'h0000_0100, 3'b111, 1'b1, 3'b010);
    step(1);
    check("t2_valid_early", 64'(irq_evt[0].valid), 64'd0);
    check("t2_pending",     64'(irq_pending[2:0]), 64'h2);
    irq_src[0*3 +: 3] = 3'b000;
    step(1);
    check_evt("t2_evt", 0, 32'h0000_0100, 32'h8000_0007);
    step(1);
    check("t2_single",  64'(irq_evt[0].valid), 64'd0);
    check("t2_we_low",  64'(mcause_we[0]),     64'd0);
    check("t2_service", 64'(in_service[0]),    64'd1);
    do_mret(0);
    check("t2_mret_idle", 64'(in_service[0]), 64'd0);

    // 3. Vectored mode, MTI+MEI together: MEI wins.
    cfg_hart(1, 32'h0000_0201, 3'b111, 1'b1, 3'b110);
    step(1);
    check("t3_pending", 64'(irq_pending[5:3]), 64'h6);
    step(1);
    check_evt("t3_evt", 1, 32'h0000_022C, 32'h8000_000B);
    // MRET arriving while in FIRE is ignored; switch source to MSI and hold it.
    irq_src[1*3 +: 3] = 3'b001;
    do_mret(1);
    check("t3_fire_mret_ignored", 64'(in_service[1]),    64'd1);
    check("t3_no_refire",         64'(irq_evt[1].valid), 64'd0);
    step(2);
    check("t3_service_hold", 64'(irq_evt[1].valid), 64'd0);
    check("t3_pending_msi",  64'(irq_pending[5:3]), 64'h1);

    // 4. MRET flow: wrong hart ignored, right hart releases and re-fires.
    do_mret(0);
    check("t4_wrong_hart",  64'(in_service[1]),    64'd1);
    check("t4_wrong_valid", 64'(irq_evt[1].valid), 64'd0);
    check("t4_hart0_idle",  64'(in_service[0]),    64'd0);
    do_mret(1);
    check("t4_released",     64'(in_service[1]),    64'd0);
    check("t4_idle_gap",     64'(irq_evt[1].valid), 64'd0);
    step(1);
    check_evt("t4_refire", 1, 32'h0000_020C, 32'h8000_0003);
    irq_src[1*3 +: 3] = 3'b000;
    step(1);
    check("t4_mcause_hold", 64'(mcause[1*32 +: 32]), 64'h8000_0003);
    do_mret(1);
    check("t4_idle_end", 64'(in_service[1]), 64'd0);
    step(1);
    check("t4_no_evt_end", 64'(irq_evt[1].valid), 64'd0);

    // 5. Masking on hart 3.
    cfg_hart(3, 32'h0000_0500, 3'b000, 1'b1, 3'b100);
    step(2);
    check("t5_pending_masked", 64'(irq_pending[11:9]), 64'h0);
    check("t5_no_evt_mie",     64'(irq_evt[3].valid),  64'd0);
    mie[3*3 +: 3]  = 3'b100;
    mstatus_mie[3] = 1'b0;
    step(1);
    check("t5_pending_follow", 64'(irq_pending[11:9]), 64'h4);
    step(1);
    check("t5_no_evt_gie",  64'(irq_evt[3].valid), 64'd0);
    check("t5_idle_gie",    64'(in_service[3]),    64'd0);
    mstatus_mie[3] = 1'b1;
    step(1);
    check_evt("t5_evt", 3, 32'h0000_0500, 32'h8000_000B);
    irq_src[3*3 +: 3] = 3'b000;
    step(1);
    do_mret(3);
    check("t5_idle_end", 64'(in_service[3]), 64'd0);

    // 6. MEI on every hart in the same cycle, each with its own mtvec.
    for (int h = 0; h < NH; h++) begin
      cfg_hart(h, 32'((h + 1) << 12), 3'b111, 1'b1, 3'b100);
    end
    step(1);
    check("t6_none_early", 64'(mcause_we), 64'd0);
    step(2 - 1);
    for (int h = 0; h < NH; h++) begin
      check($sformatf("t6_h%0d_valid", h),  64'(irq_evt[h].valid), 64'd1);
      check($sformatf("t6_h%0d_data", h),   64'(irq_evt[h].data),  64'((h + 1) << 12));
      check($sformatf("t6_h%0d_mcause", h), 64'(mcause[h*32 +: 32]), 64'h8000_000B);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
